csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor with valid/ready handshake on both sides.
- Successor to the 32-bit combinational adders: width and segment size are generic, one segment resolves per pipeline stage, and a subtract mode is added.
- Full-throughput (one operation per cycle), in-order, with stall propagation. Sits between the operand-issue logic and the result writeback.

Parameters:
- WIDTH, 32, operand/sum width in bits.
- SEG_W, 8, carry-select segment width; NSEG = WIDTH/SEG_W pipeline stages. WIDTH % SEG_W != 0 or SEG_W < 1 is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (add mode only)
- sub  in  1  0: a+b+cin; 1: a-b (a+~b+1, cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- of  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits clear. Next cycle: out_valid=0, sum=0, cout=0, of=0, zero=0, in_ready=1. Reset mid-operation discards all in-flight ops, with no partial output. Data registers other than outputs need not be reset.
- Accept: in_valid && in_ready at a clk edge. Operands are captured with b_eff = sub ? ~b : b and c0 = sub ? 1 : cin.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. While stall=1, every stage register holds (global enable); there is no bubble collapse.
- Stage k (0..NSEG-1) resolves segment k using the carry-select method:
  - Compute both seg(a)+seg(b_eff)+0 and +1.
  - Select with the registered carry from stage k-1 (stage 0 uses c0).
  - Register the selected SEG_W sum bits, the carry out, and the still-unprocessed upper operand segments.
- Latency: exactly NSEG cycles from accept edge to out_valid=1 when no stall. Throughput is 1/cycle.
- Final-stage flags:
  - cout = carry out of segment NSEG-1.
  - of = carry into bit WIDTH-1 XOR cout.
  - zero = (sum == 0).
- Outputs are registered. sum/cout/of/zero stay stable while out_valid && !out_ready.
- Ordering: results leave strictly in acceptance order. No drop, no duplication.
- Accept and output on the same edge are legal: the pipeline advances and the new op enters stage 0.
- in_valid=0 inserts a bubble. Bubbles flow through; out_valid=0 for them.
- Any X on a/b while in_valid=0 must not affect outputs.
- Width rules: sum is modulo 2^WIDTH. No sign extension of inputs.
- NSEG=1 (SEG_W=WIDTH) degenerates to a single registered carry-select stage with latency 1.

Test Plan:
- WIDTH=32, SEG_W=8, add, cin=0: a=0x5FFFE8CA, b=0x54F4FFFF -> after 4 cycles sum=0xB4F4E8C9, cout=0, of=1, zero=0.
- Add, cin=0: a=0xA0A0FFFF, b=0xA0BFFFE0 -> sum=0x4160FFDF, cout=1, of=1. Then add, cin=1: a=0xDFFFE8CA, b=0xCFFFF8CA -> sum=0xAFFFE195, cout=1, of=0. Issue back-to-back; outputs appear on consecutive cycles.
- Sub: a=5, b=7 -> sum=0xFFFFFFFE, cout=0, of=0. Sub: a=0x12345678, b=0x12345678 -> sum=0, cout=1, zero=1. Sub: a=0x80000000, b=1 -> sum=0x7FFFFFFF, of=1.
- Backpressure: stream 6 random ops continuously, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, all 6 results match the reference model in order, none lost or repeated.
- Reset mid-stream: 3 ops in flight, assert rst for 1 cycle -> out_valid=0 from the next cycle, and none of the 3 results ever appears.
- Parameter sweep WIDTH=16/SEG_W=4 and WIDTH=8/SEG_W=8: 1000 random add/sub ops each vs behavioural model, with latency = NSEG.

Source files
------------

// File: rtl/csel_adder_pipe.sv
// -----------------------------------------------------------------------------
// csel_adder_pipe
//
// Pipelined carry-select adder/subtractor. The WIDTH-bit operation is cut into
// NSEG = WIDTH/SEG_W segments, and one segment is resolved per pipeline stage.
// Each stage computes its segment twice, once with carry-in 0 and once with
// carry-in 1. The registered carry from the stage before it then selects one
// of the two results. Subtraction is a + ~b + 1.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept an operation this cycle
//   a, b       in   WIDTH-bit operands
//   cin        in   carry in (add mode only)
//   sub        in   0: a+b+cin, 1: a-b (cin ignored)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   sum        out  WIDTH-bit result (modulo 2^WIDTH)
//   cout       out  carry out of the MSB (subtract: 1 = no borrow)
//   of         out  signed overflow
//   zero       out  sum == 0
//
// Handshake: a transfer happens on a clk edge where valid && ready are both 1,
// on either side. in_ready = !(out_valid && !out_ready). A stalled output
// freezes every stage at once through a single global enable, so bubbles are
// not squeezed out. out_valid and the data it qualifies stay stable until the
// result is taken. in_ready does not depend on in_valid.
//
// Latency: an operation accepted on edge t shows out_valid=1 right after edge
// t+NSEG-1. That means NSEG register ranks, and NSEG cycles counted from the
// accept cycle.
// -----------------------------------------------------------------------------
module csel_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of,
    output logic             zero
);

    // Guarded divisor so that a bad SEG_W reaches the check below instead of
    // failing on a divide by zero first.
    localparam int SEG_SAFE = (SEG_W < 1) ? 1 : SEG_W;
    localparam int NSEG     = (WIDTH / SEG_SAFE < 1) ? 1 : WIDTH / SEG_SAFE;

    if ((SEG_W < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_param_check
        $error("csel_adder_pipe: WIDTH must be a positive multiple of SEG_W");
    end

    // Per-stage registers. Entry k holds what stage k produced.
    //   a_q/b_q : operands not yet processed, shifted down so that the next
    //             segment always sits in the low SEG_W bits
    //   s_q     : sum bits resolved so far, in their final bit positions
    //   c_q     : carry out of the segment this stage resolved
    logic [NSEG-1:0]  vld_q;
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic [NSEG-1:0]  c_q;
    logic             of_q;
    logic             zero_q;

    // Next-state values for each stage.
    logic [WIDTH-1:0] a_d [NSEG];
    logic [WIDTH-1:0] b_d [NSEG];
    logic [WIDTH-1:0] s_d [NSEG];
    logic [NSEG-1:0]  c_d;
    logic             of_d;
    logic             zero_d;

    // Inputs seen by each stage: the ports for stage 0, and the register of
    // the stage before it for every later stage.
    logic [WIDTH-1:0] st_a [NSEG];
    logic [WIDTH-1:0] st_b [NSEG];
    logic [WIDTH-1:0] st_s [NSEG];
    logic [NSEG-1:0]  st_c;
    logic [NSEG-1:0]  st_v;

    logic [SEG_W:0]   seg_r [NSEG];
    logic             msb_cin;
    logic             stall;
    logic             adv;

    // One carry-select segment. Both candidate sums are formed and the
    // incoming carry selects one of them, so the carry chain crossing a
    // stage is a single mux.
    function automatic logic [SEG_W:0] csel_seg(input logic [SEG_W-1:0] x,
                                                input logic [SEG_W-1:0] y,
                                                input logic             c);
        logic [SEG_W:0] r0;
        logic [SEG_W:0] r1;
        r0 = {1'b0, x} + {1'b0, y};
        r1 = {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, 1'b1};
        return c ? r1 : r0;
    endfunction

    assign stall    = vld_q[NSEG-1] && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall;

    always_comb begin
        st_a[0] = a;
        st_b[0] = sub ? ~b : b;
        st_c[0] = sub | cin;
        st_s[0] = '0;
        st_v[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = c_q[k-1];
            st_s[k] = s_q[k-1];
            st_v[k] = vld_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            seg_r[k] = csel_seg(st_a[k][SEG_W-1:0], st_b[k][SEG_W-1:0], st_c[k]);
            a_d[k]   = st_a[k] >> SEG_W;
            b_d[k]   = st_b[k] >> SEG_W;
            s_d[k]   = st_s[k];
            s_d[k][k*SEG_W +: SEG_W] = seg_r[k][SEG_W-1:0];
            c_d[k]   = seg_r[k][SEG_W];
        end
        // The sum MSB is a ^ b ^ carry_in, so the carry into the MSB can be
        // recovered from the operand bits and the selected sum bit.
        msb_cin = st_a[NSEG-1][SEG_W-1] ^ st_b[NSEG-1][SEG_W-1]
                ^ seg_r[NSEG-1][SEG_W-1];
        of_d    = msb_cin ^ c_d[NSEG-1];
        zero_d  = (s_d[NSEG-1] == '0);
    end

    // Valid bits advance together. A bubble (st_v=0) shifts in as a 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= st_v;
        end
    end

    // Data registers load only for a live operation, so operand values
    // driven under in_valid=0 never reach the outputs. Only the output stage
    // is cleared on reset. Inner stages are qualified by vld_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q[NSEG-1] <= '0;
            c_q[NSEG-1] <= 1'b0;
            of_q        <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSEG; k++) begin
                if (st_v[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (st_v[NSEG-1]) begin
                of_q   <= of_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = vld_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];
    assign of        = of_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
module tb_csel_adder_pipe;

  logic clk;
  logic rst;

  logic        iv32, ir32, ov32, or32, cin32, sub32, co32, of32, z32;
  logic [31:0] a32, b32, s32;
  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16, z16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ov8, or8, cin8, sub8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;

  int n_checks;
  int n_fail;

  logic [31:0] vec_a [6];
  logic [31:0] vec_b [6];
  logic        vec_cin [6];
  logic        vec_sub [6];
  logic [31:0] exp_sum [6];
  logic        exp_cout [6];
  logic        exp_of [6];
  logic        exp_zero [6];

  logic [34:0] exp_q [$];
  logic [34:0] exp16_q [$];
  logic [34:0] exp8_q [$];
  int          ts16_q [$];
  int          ts8_q [$];

  csel_adder_pipe #(.WIDTH(32), .SEG_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .of(of32), .zero(z32)
  );

  csel_adder_pipe #(.WIDTH(16), .SEG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .of(of16), .zero(z16)
  );

  csel_adder_pipe #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .of(of8), .zero(z8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: {cout, of, zero, sum} for a w-bit operation.
  function automatic logic [34:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci,
                                        input logic sb);
    logic [63:0] full;
    logic [31:0] mask, xm, ym, s;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    xm   = x & mask;
    ym   = (sb ? ~y : y) & mask;
    full = {32'h0, xm} + {32'h0, ym} + {63'h0, (sb | ci)};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {co, ov, (s == 32'h0), s};
  endfunction

  task automatic drive32(input int i);
    a32 = vec_a[i]; b32 = vec_b[i]; cin32 = vec_cin[i]; sub32 = vec_sub[i];
    iv32 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov32); end
    n_checks++; if (s32 !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", s32); end
    n_checks++; if (co32 !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", co32); end
    n_checks++; if (of32 !== 1'b0) begin n_fail++; $display("FAIL reset_of: got %b want 0", of32); end
    n_checks++; if (z32 !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", z32); end
    n_checks++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ir32); end
    n_checks++; if (ov16 !== 1'b0 || s16 !== 16'h0) begin n_fail++; $display("FAIL reset_w16: got v=%b s=%h want 0/0", ov16, s16); end
    n_checks++; if (ov8 !== 1'b0 || s8 !== 8'h0) begin n_fail++; $display("FAIL reset_w8: got v=%b s=%h want 0/0", ov8, s8); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_single();
    drive32(0);
    tick();
    iv32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'hFFFF_FFFF; cin32 = 1'b1;
    for (int c = 1; c < 4; c++) begin
      n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL add_latency edge %0d: got out_valid %b want 0", c, ov32); end
      tick();
    end
    n_checks++; if (ov32 !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", ov32); end
    n_checks++; if (s32 !== exp_sum[0]) begin n_fail++; $display("FAIL add_sum: got %h want %h", s32, exp_sum[0]); end
    n_checks++; if (co32 !== exp_cout[0]) begin n_fail++; $display("FAIL add_cout: got %b want %b", co32, exp_cout[0]); end
    n_checks++; if (of32 !== exp_of[0]) begin n_fail++; $display("FAIL add_of: got %b want %b", of32, exp_of[0]); end
    n_checks++; if (z32 !== exp_zero[0]) begin n_fail++; $display("FAIL add_zero: got %b want %b", z32, exp_zero[0]); end
    tick();
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL add_bubble: got out_valid %b want 0", ov32); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 2; i++) begin
      drive32(i);
      tick();
    end
    iv32 = 1'b0;
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL b2b_early2: got %b want 0", ov32); end
    tick();
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL b2b_early3: got %b want 0", ov32); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks++; if (ov32 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ov32); end
      n_checks++; if (s32 !== exp_sum[i]) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %h want %h", i, s32, exp_sum[i]); end
      n_checks++; if (co32 !== exp_cout[i]) begin n_fail++; $display("FAIL b2b_cout[%0d]: got %b want %b", i, co32, exp_cout[i]); end
      n_checks++; if (of32 !== exp_of[i]) begin n_fail++; $display("FAIL b2b_of[%0d]: got %b want %b", i, of32, exp_of[i]); end
      n_checks++; if (z32 !== exp_zero[i]) begin n_fail++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, z32, exp_zero[i]); end
    end
    tick();
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", ov32); end
  endtask

  task automatic test_sub();
    for (int i = 3; i <= 5; i++) begin
      drive32(i);
      tick();
    end
    iv32 = 1'b0;
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL sub_early: got %b want 0", ov32); end
    for (int i = 3; i <= 5; i++) begin
      tick();
      n_checks++; if (ov32 !== 1'b1) begin n_fail++; $display("FAIL sub_valid[%0d]: got %b want 1", i, ov32); end
      n_checks++; if (s32 !== exp_sum[i]) begin n_fail++; $display("FAIL sub_sum[%0d]: got %h want %h", i, s32, exp_sum[i]); end
      n_checks++; if (co32 !== exp_cout[i]) begin n_fail++; $display("FAIL sub_cout[%0d]: got %b want %b", i, co32, exp_cout[i]); end
      n_checks++; if (of32 !== exp_of[i]) begin n_fail++; $display("FAIL sub_of[%0d]: got %b want %b", i, of32, exp_of[i]); end
      n_checks++; if (z32 !== exp_zero[i]) begin n_fail++; $display("FAIL sub_zero[%0d]: got %b want %b", i, z32, exp_zero[i]); end
    end
    tick();
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL sub_drain: got %b want 0", ov32); end
  endtask

  task automatic test_backpressure();
    int          issued, popped, it;
    logic        acc, want_ready;
    logic [34:0] e, g;
    issued = 0; popped = 0;
    exp_q.delete();
    for (it = 0; it < 60 && popped < 6; it++) begin
      if (!iv32 && issued < 6) begin
        a32 = $urandom; b32 = $urandom;
        cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
        iv32 = 1'b1;
      end
      or32 = !(it >= 4 && it <= 6);
      #1;
      want_ready = !(it >= 4 && it <= 6);
      if (it < 14) begin
        n_checks++; if (ir32 !== want_ready) begin n_fail++; $display("FAIL bp_in_ready it=%0d: got %b want %b", it, ir32, want_ready); end
      end
      acc = iv32 && ir32;
      if (acc) begin
        exp_q.push_back(model(32, a32, b32, cin32, sub32));
        issued++;
      end
      if (ov32 && or32) begin
        g = {co32, of32, z32, s32};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_result: got %h want none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin n_fail++; $display("FAIL bp_result[%0d]: got %h want %h", popped, g, e); end
        end
        popped++;
      end
      tick();
      if (acc) iv32 = 1'b0;
    end
    iv32 = 1'b0; or32 = 1'b1;
    n_checks++; if (popped != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", popped); end
    for (int c = 0; c < 6; c++) begin
      n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate c=%0d: got out_valid %b want 0", c, ov32); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      a32 = 32'h1111_1111 * (i + 1); b32 = 32'h0F0F_0F0F; cin32 = 1'b0; sub32 = 1'b0;
      iv32 = 1'b1;
      tick();
    end
    iv32 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", ov32); end
    n_checks++; if (s32 !== 32'h0) begin n_fail++; $display("FAIL rstmid_sum: got %h want 0", s32); end
    n_checks++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", ir32); end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost c=%0d: got out_valid %b sum %h want 0", c, ov32, s32); end
    end
  endtask

  task automatic test_sweep();
    int          acc16, acc8, got16, got8, it, t;
    logic        a16f, a8f;
    logic [34:0] e, g;
    acc16 = 0; acc8 = 0; got16 = 0; got8 = 0;
    exp16_q.delete(); exp8_q.delete(); ts16_q.delete(); ts8_q.delete();
    or16 = 1'b1; or8 = 1'b1;
    for (it = 0; it < 4000 && (got16 < 1000 || got8 < 1000); it++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
      iv16 = (acc16 < 1000) && ($urandom_range(0, 9) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
      iv8 = (acc8 < 1000) && ($urandom_range(0, 9) != 0);
      #1;
      a16f = iv16 && ir16;
      a8f  = iv8 && ir8;
      if (a16f) begin
        exp16_q.push_back(model(16, {16'h0, a16}, {16'h0, b16}, cin16, sub16));
        ts16_q.push_back(it); acc16++;
      end
      if (a8f) begin
        exp8_q.push_back(model(8, {24'h0, a8}, {24'h0, b8}, cin8, sub8));
        ts8_q.push_back(it); acc8++;
      end
      if (ov16) begin
        g = {co16, of16, z16, 16'h0, s16};
        n_checks++;
        if (exp16_q.size() == 0) begin
          n_fail++; $display("FAIL w16_extra: got %h want none", g);
        end else begin
          e = exp16_q.pop_front(); t = ts16_q.pop_front();
          if (g !== e) begin n_fail++; $display("FAIL w16_result[%0d]: got %h want %h", got16, g, e); end
          n_checks++; if (it - t != 4) begin n_fail++; $display("FAIL w16_latency[%0d]: got %0d want 4", got16, it - t); end
        end
        got16++;
      end
      if (ov8) begin
        g = {co8, of8, z8, 24'h0, s8};
        n_checks++;
        if (exp8_q.size() == 0) begin
          n_fail++; $display("FAIL w8_extra: got %h want none", g);
        end else begin
          e = exp8_q.pop_front(); t = ts8_q.pop_front();
          if (g !== e) begin n_fail++; $display("FAIL w8_result[%0d]: got %h want %h", got8, g, e); end
          n_checks++; if (it - t != 1) begin n_fail++; $display("FAIL w8_latency[%0d]: got %0d want 1", got8, it - t); end
        end
        got8++;
      end
      tick();
    end
    iv16 = 1'b0; iv8 = 1'b0;
    n_checks++; if (got16 != 1000) begin n_fail++; $display("FAIL w16_count: got %0d want 1000", got16); end
    n_checks++; if (got8 != 1000) begin n_fail++; $display("FAIL w8_count: got %0d want 1000", got8); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; or8  = 1'b1;

    // Directed vectors with hand-computed results.
    vec_a[0] = 32'h5FFF_E8CA; vec_b[0] = 32'h54F4_FFFF; vec_cin[0] = 1'b0; vec_sub[0] = 1'b0;
    exp_sum[0] = 32'hB4F4_E8C9; exp_cout[0] = 1'b0; exp_of[0] = 1'b1; exp_zero[0] = 1'b0;
    vec_a[1] = 32'hA0A0_FFFF; vec_b[1] = 32'hA0BF_FFE0; vec_cin[1] = 1'b0; vec_sub[1] = 1'b0;
    exp_sum[1] = 32'h4160_FFDF; exp_cout[1] = 1'b1; exp_of[1] = 1'b1; exp_zero[1] = 1'b0;
    vec_a[2] = 32'hDFFF_E8CA; vec_b[2] = 32'hCFFF_F8CA; vec_cin[2] = 1'b1; vec_sub[2] = 1'b0;
    exp_sum[2] = 32'hAFFF_E195; exp_cout[2] = 1'b1; exp_of[2] = 1'b0; exp_zero[2] = 1'b0;
    vec_a[3] = 32'h0000_0005; vec_b[3] = 32'h0000_0007; vec_cin[3] = 1'b1; vec_sub[3] = 1'b1;
    exp_sum[3] = 32'hFFFF_FFFE; exp_cout[3] = 1'b0; exp_of[3] = 1'b0; exp_zero[3] = 1'b0;
    vec_a[4] = 32'h1234_5678; vec_b[4] = 32'h1234_5678; vec_cin[4] = 1'b0; vec_sub[4] = 1'b1;
    exp_sum[4] = 32'h0000_0000; exp_cout[4] = 1'b1; exp_of[4] = 1'b0; exp_zero[4] = 1'b1;
    vec_a[5] = 32'h8000_0000; vec_b[5] = 32'h0000_0001; vec_cin[5] = 1'b0; vec_sub[5] = 1'b1;
    exp_sum[5] = 32'h7FFF_FFFF; exp_cout[5] = 1'b1; exp_of[5] = 1'b1; exp_zero[5] = 1'b0;

    #1;
    test_reset();
    test_add_single();
    test_back_to_back();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
